// File: rtl/core_pkg.sv
// Shared core definitions: load func3 encodings, default datapath width
// and operand-select encodings for the lock-forward path.
package core_pkg;

  localparam int XLEN_DEF = 32;

  // RISC-V load func3 encodings
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_f3_e;

  // Operand select for the lock-forward override
  localparam logic RS1 = 1'b0;
  localparam logic RS2 = 1'b1;

endpackage

// File: rtl/mem_wb_pipe_reg_load_align.sv
// load_align: combinational load-data alignment with sign/zero extension.
// The raw word is shifted down by the byte offset; any bits shifted past
// the top are simply lost (misaligned accesses are not trapped here).
module load_align
  import core_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int OFF_W = (XLEN == 64) ? 3 : 2
) (
  input  logic [2:0]       func3,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  raw,
  output logic [XLEN-1:0]  ext
);

  logic [XLEN-1:0] shifted;

  assign shifted = raw >> {offset, 3'b000};

  // Select extension by load type; unknown types pass the raw word
  always_comb begin
    ext = raw;
    case (func3)
      F3_LB:   ext = XLEN'($signed(shifted[7:0]));
      F3_LH:   ext = XLEN'($signed(shifted[15:0]));
      F3_LW:   ext = XLEN'($signed(shifted[31:0]));
      F3_LBU:  ext = XLEN'(shifted[7:0]);
      F3_LHU:  ext = XLEN'(shifted[15:0]);
      F3_LWU:  ext = (XLEN == 64) ? XLEN'(shifted[31:0]) : raw;
      F3_LD:   ext = (XLEN == 64) ? shifted : raw;
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg: MEM/WB pipeline register with stall/flush, valid bit,
// registered load alignment and a LOCK_DEPTH-entry lock-forward FIFO.
// Optional feature macro: MEM_WB_PERF_CNT_EN adds retire/bubble counters.
module mem_wb_pipe_reg
  import core_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_IDX_W  = 5,
  parameter int LOCK_DEPTH = 2,
  parameter int RS_SEL_W   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 mem_valid,
  input  logic                 mem_mux_rd,
  input  logic                 mem_regfile_en,
  input  logic [2:0]           mem_func3,
  input  logic [REG_IDX_W-1:0] mem_rd_index,
  input  logic [XLEN-1:0]      mem_dm_dataout,
  input  logic [XLEN-1:0]      mem_alu_result,
  input  logic                 lock_req,
  input  logic [RS_SEL_W-1:0]  lock_rs,
  input  logic [XLEN-1:0]      lock_fwd_data,
  input  logic                 lock_consume,
  output logic                 wb_valid,
  output logic                 wb_mux_rd,
  output logic                 wb_regfile_en,
  output logic [2:0]           wb_func3,
  output logic [REG_IDX_W-1:0] wb_rd_index,
  output logic [XLEN-1:0]      wb_load_data,
  output logic [XLEN-1:0]      wb_alu_result,
  output logic [XLEN-1:0]      wb_data,
  output logic                 lock_valid,
  output logic [XLEN-1:0]      lock_data,
  output logic [RS_SEL_W-1:0]  lock_sel,
  output logic                 lock_full,
  output logic                 lock_overflow
`ifdef MEM_WB_PERF_CNT_EN
  ,
  output logic [31:0]          retire_cnt,
  output logic [31:0]          bubble_cnt
`endif
);

  localparam int OFF_W = (XLEN == 64) ? 3 : 2;
  // Depth 1 still needs a 1-bit pointer; wrap is handled explicitly.
  localparam int PTR_W = (LOCK_DEPTH > 1) ? $clog2(LOCK_DEPTH) : 1;
  localparam int CNT_W = $clog2(LOCK_DEPTH + 1);

  logic            advance;
  logic [XLEN-1:0] align_data;

  assign advance = ~flush & ~stall;

  load_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
    .func3  (mem_func3),
    .offset (mem_alu_result[OFF_W-1:0]),
    .raw    (mem_dm_dataout),
    .ext    (align_data)
  );

  // WB stage registers: flush kills the instruction but keeps its payload
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_mux_rd     <= 1'b0;
      wb_regfile_en <= 1'b0;
      wb_func3      <= '0;
      wb_rd_index   <= '0;
      wb_load_data  <= '0;
      wb_alu_result <= '0;
    end else if (flush) begin
      wb_valid      <= 1'b0;
      wb_regfile_en <= 1'b0;
    end else if (advance) begin
      wb_valid      <= mem_valid;
      wb_mux_rd     <= mem_mux_rd;
      wb_regfile_en <= mem_regfile_en & mem_valid;
      wb_func3      <= mem_func3;
      wb_rd_index   <= mem_rd_index;
      wb_load_data  <= align_data;
      wb_alu_result <= mem_alu_result;
    end
  end

  assign wb_data = wb_mux_rd ? wb_load_data : wb_alu_result;

  // ---------------------------------------------------------------------
  // Lock-forward queue (runs regardless of stall)
  // ---------------------------------------------------------------------
  logic [XLEN-1:0]     q_data [LOCK_DEPTH];
  logic [RS_SEL_W-1:0] q_sel  [LOCK_DEPTH];
  logic [PTR_W-1:0]    head, tail;
  logic [CNT_W-1:0]    count;
  logic                pop, push_ok, drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LOCK_DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
  endfunction

  assign lock_valid = (count != '0);
  assign lock_full  = (count == CNT_W'(LOCK_DEPTH));
  assign lock_data  = q_data[head];
  assign lock_sel   = q_sel[head];

  // A full queue still accepts a push when the head leaves the same cycle
  assign pop     = lock_consume & lock_valid;
  assign push_ok = lock_req & (~lock_full | pop);
  assign drop    = lock_req & lock_full & ~pop;

  // Queue pointers, count, entries and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      lock_overflow <= 1'b0;
      for (int i = 0; i < LOCK_DEPTH; i++) begin
        q_data[i] <= '0;
        q_sel[i]  <= '0;
      end
    end else if (flush) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      lock_overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        q_data[tail] <= lock_fwd_data;
        q_sel[tail]  <= lock_rs;
        tail         <= ptr_inc(tail);
      end
      if (pop)
        head <= ptr_inc(head);
      if (push_ok && !pop)
        count <= CNT_W'(count + 1'b1);
      else if (pop && !push_ok)
        count <= CNT_W'(count - 1'b1);
      if (drop)
        lock_overflow <= 1'b1;
    end
  end

`ifdef MEM_WB_PERF_CNT_EN
  // Retire/bubble counters; flushes count as bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end else if (advance) begin
      if (mem_valid)
        retire_cnt <= retire_cnt + 32'd1;
      else
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
- Parametrised MEM/WB pipeline register sitting between data-memory access and register-file writeback.
- Adds stall and flush control, a per-stage valid bit, and registered load-data alignment with sign/zero extension.
- Replaces the single-cycle load-use lock with a LOCK_DEPTH-entry lock-forward queue that holds each entry until the EX forward mux consumes it.

Parameters:
- XLEN, 32, datapath width; must be 32 or 64.
- REG_IDX_W, 5, register index width.
- LOCK_DEPTH, 2, lock-forward queue entries; power of two, ≥1.
- RS_SEL_W, 1, operand-select width (0=rs1, 1=rs2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  hold all stage registers.
- flush  in  1  insert bubble; clear lock queue.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_mux_rd  in  1  writeback select: 1=load data, 0=ALU result.
- mem_regfile_en  in  1  register-file write enable.
- mem_func3  in  3  load type.
- mem_rd_index  in  REG_IDX_W  destination register.
- mem_dm_dataout  in  XLEN  raw memory word.
- mem_alu_result  in  XLEN  ALU result / address.
- lock_req  in  1  load-use lock push request.
- lock_rs  in  RS_SEL_W  operand to be overridden.
- lock_fwd_data  in  XLEN  data to lock.
- lock_consume  in  1  EX forward mux consumed the queue head.
- wb_valid  out  1  WB stage holds a real instruction.
- wb_mux_rd  out  1  registered mux select.
- wb_regfile_en  out  1  registered write enable, gated by wb_valid.
- wb_func3  out  3  registered load type.
- wb_rd_index  out  REG_IDX_W  registered destination register.
- wb_load_data  out  XLEN  aligned, extended load data.
- wb_alu_result  out  XLEN  registered ALU result.
- wb_data  out  XLEN  final writeback value (mux of the two above).
- lock_valid  out  1  queue head valid.
- lock_data  out  XLEN  queue head data.
- lock_sel  out  RS_SEL_W  queue head operand select.
- lock_full  out  1  queue full.
- lock_overflow  out  1  sticky: push dropped because queue was full.

Behaviour:
- Reset: every output and queue entry is 0, including data registers. The old partial reset is not kept.
- Latency: MEM to WB is one cycle; load alignment is computed in the MEM cycle and registered.
- Priority per cycle: rst > flush > stall > advance.
- flush:
  - wb_valid and wb_regfile_en go to 0; other WB fields keep their values.
  - Lock queue is emptied.
  - lock_overflow is cleared.
- stall (no flush): all WB registers hold their values.
- Advance: all mem_* fields are captured; wb_valid is set from mem_valid; wb_regfile_en is set from mem_regfile_en & mem_valid.
- Load alignment uses byte offset alu_result[1:0] (XLEN=64: [2:0]).
  - func3 000 = LB, sign-extend.
  - 001 = LH, sign-extend.
  - 010 = LW, sign-extend to XLEN when XLEN=64.
  - 100 = LBU, zero-extend.
  - 101 = LHU, zero-extend.
  - 110 = LWU, zero-extend; XLEN=64 only.
  - 011 = LD; XLEN=64 only.
  - Any other func3 passes the raw word through.
  - Misaligned halfwords/words are not checked; the shifted word is truncated.
- wb_data is combinational from registered state: wb_mux_rd ? wb_load_data : wb_alu_result.
- Lock queue is a circular FIFO with head/tail pointers of $clog2(LOCK_DEPTH) bits plus a count.
  - Push on lock_req; pop on lock_consume & lock_valid.
  - Queue operates independently of stall; flush overrides it.
  - Push while full without a same-cycle pop: entry is dropped and lock_overflow is set (sticky until rst or flush).
  - Simultaneous push and pop when full: both occur; count is unchanged and no overflow.
  - Simultaneous push and pop when empty: the pushed entry becomes the head next cycle; it is not bypassed.
  - lock_consume while empty: ignored.
  - Pointers wrap modulo LOCK_DEPTH.
  - lock_valid = (count != 0); lock_full = (count == LOCK_DEPTH).
- rst mid-operation: queue is emptied and all outputs return to 0 on the next edge.

Optional Feature:
- Macro MEM_WB_PERF_CNT_EN adds the following outputs:
  - retire_cnt (32-bit): increments on each advance with mem_valid=1.
  - bubble_cnt (32-bit): increments on each advance with mem_valid=0 and on each flush.
  - Both counters wrap and clear on rst.
- Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package core_pkg:
  - func3 load encodings (F3_LB … F3_LWU).
  - XLEN default.
  - RS_SEL encodings RS1 = 0, RS2 = 1.
- Sub-module load_align (combinational): inputs func3, offset, raw word; output extended value. Instantiated once.
- The lock queue stays inline.

Test Plan:
- LB, dm_dataout=0x12345680, alu_result[1:0]=00, advance → next cycle wb_load_data=0xFFFFFF80, wb_data equals it with mux_rd=1.
- LHU, dm=0xBEEF0000, offset=10 → wb_load_data=0x0000BEEF. Then stall for 3 cycles with new inputs → WB outputs unchanged.
- Three pushes (0xA, 0xB, 0xC) with LOCK_DEPTH=2, no consume → lock_full=1, lock_overflow=1, head=0xA. Consume twice → 0xB, then lock_valid=0.
- Full queue with push 0xD and consume in the same cycle → count stays 2, head=0xB, no overflow.
- flush while wb_valid=1 and queue holds 1 entry → wb_valid=0, wb_regfile_en=0, lock_valid=0, lock_overflow=0.
- rst asserted mid-stream with the queue non-empty → all outputs 0 the next cycle; with MEM_WB_PERF_CNT_EN, counters read 0.
